// File: rtl/uart_fifo_tx.sv
// FIFO-draining 8N1 UART transmitter: pops one byte per frame from a first-word-latency-1 FIFO
// and serialises it LSB first. Every output is registered from the next-state values.
module uart_fifo_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int STOP_BITS    = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 I_rst,
  input  logic                 I_enable,
  input  logic                 I_fifo_empty,
  input  logic [7:0]           I_fifo_q,
  output logic                 O_fifo_rd_en,
  output logic                 O_uart_tx,
  output logic                 O_busy,
  output logic                 O_byte_done,
  output logic [CNT_WIDTH-1:0] O_byte_count
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic              tx_nxt, done_nxt, go;

  assign go = I_enable & ~I_fifo_empty;

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    unique case (state)
      IDLE:  if (go) state_nxt = FETCH;
      FETCH: state_nxt = LOAD;
      LOAD: begin
        shreg_nxt = I_fifo_q;
        state_nxt = START;
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_nxt  = '0;
          shreg_nxt = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_nxt   = '0;
            state_nxt = go ? FETCH : IDLE;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with the state.
    tx_nxt = 1'b1;
    if (state_nxt == START)     tx_nxt = 1'b0;
    else if (state_nxt == DATA) tx_nxt = shreg_nxt[0];
    done_nxt = (state_nxt == STOP) && (baud_nxt == BAUD_LAST) && (bit_nxt == STOP_LAST);
  end

  always_ff @(posedge clk or posedge I_rst) begin
    if (I_rst) begin
      state        <= IDLE;
      baud         <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      O_fifo_rd_en <= 1'b0;
      O_uart_tx    <= 1'b1;
      O_busy       <= 1'b0;
      O_byte_done  <= 1'b0;
      O_byte_count <= '0;
    end else begin
      state        <= state_nxt;
      baud         <= baud_nxt;
      bit_cnt      <= bit_nxt;
      shreg        <= shreg_nxt;
      O_fifo_rd_en <= (state_nxt == FETCH);
      O_uart_tx    <= tx_nxt;
      O_busy       <= (state_nxt != IDLE);
      O_byte_done  <= done_nxt;
      if (done_nxt) O_byte_count <= O_byte_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx: a small FIFO model feeds the main instance (1 stop bit,
// 4-bit counter); a second instance with 2 stop bits measures frame length.
module tb_uart_fifo_tx;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_q;
  logic        rd_en, tx, busy, done;
  logic [3:0]  count;

  logic        en2, e2;
  logic [7:0]  q2;
  logic        rd_en2, tx2, busy2, done2;
  logic [15:0] count2;

  logic [7:0]  mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  logic        uf = 1'b0;
  int          tests = 0;
  int          fails = 0;

  uart_fifo_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .CNT_WIDTH(4)) dut (
    .clk(clk), .I_rst(rst), .I_enable(en), .I_fifo_empty(fifo_empty), .I_fifo_q(fifo_q),
    .O_fifo_rd_en(rd_en), .O_uart_tx(tx), .O_busy(busy), .O_byte_done(done),
    .O_byte_count(count)
  );

  uart_fifo_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .I_rst(rst), .I_enable(en2), .I_fifo_empty(e2), .I_fifo_q(q2),
    .O_fifo_rd_en(rd_en2), .O_uart_tx(tx2), .O_busy(busy2), .O_byte_done(done2),
    .O_byte_count(count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port: Q updates the cycle after RdEn.
  always @(posedge clk) begin
    if (rd_en && fifo_empty) uf <= 1'b1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (rd_en && !fifo_empty) begin
      fifo_q <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Waits (bounded) for a start bit, then samples all 40 cycles of a 1-stop-bit frame.
  // gap = negedges advanced from call until the start bit was seen.
  task automatic rx_frame(input logic [7:0] b, input string tag, input int drop_at,
                          output int gap);
    logic [9:0] exp_bits, obs;
    logic       stable;
    int         done_n, done_at;
    exp_bits = {1'b1, b, 1'b0};
    gap = 0;
    while (tx !== 1'b0 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    chk({tag, "_start_seen"}, (gap < 200), 1'b1);
    obs = '0; stable = 1'b1; done_n = 0; done_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_at) en = 1'b0;
      if (k % 4 == 0) obs[k/4] = tx;
      else if (tx !== obs[k/4]) stable = 1'b0;
      if (done === 1'b1) begin
        done_n++;
        done_at = k;
      end
    end
    chk({tag, "_bits"}, {stable, obs}, {1'b1, exp_bits});
    chk({tag, "_byte_done"}, {done_n, done_at}, {32'd1, 32'd39});
  endtask

  initial begin
    int base, gap, bad, w, len;
    rst = 1'b1; en = 1'b0; en2 = 1'b1; e2 = 1'b1; q2 = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 4'd0);
    rst = 1'b0;
    @(negedge clk);

    // single byte 0xA5 with FETCH/LOAD latency
    base = rd_cnt;
    push(8'hA5);
    en = 1'b1;
    @(negedge clk);
    chk("t1_fetch", {rd_en, busy, tx}, 3'b111);
    @(negedge clk);
    chk("t1_load", {rd_en, tx}, 2'b01);
    @(negedge clk);
    chk("t1_start", tx, 1'b0);
    rx_frame(8'hA5, "t1", -1, gap);
    @(negedge clk);
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_count", count, 4'd1);
    chk("t1_rd_pulses", rd_cnt - base, 1);

    // three back-to-back bytes; next start bit 3 cycles after the last stop cycle
    base = rd_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    rx_frame(8'h00, "t2a", -1, gap);
    chk("t2a_latency", gap, 3);
    rx_frame(8'hFF, "t2b", -1, gap);
    chk("t2b_gap", gap, 3);
    rx_frame(8'h3C, "t2c", -1, gap);
    chk("t2c_gap", gap, 3);
    @(negedge clk);
    chk("t2_idle_busy", busy, 1'b0);
    chk("t2_count", count, 4'd4);
    chk("t2_rd_pulses", rd_cnt - base, 3);

    // empty FIFO with enable held
    base = rd_cnt; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) bad++;
    end
    chk("t3_idle_violations", bad, 0);
    chk("t3_rd_pulses", rd_cnt - base, 0);

    // drop enable in the third data bit of 0x81 with 0x55 queued behind it
    base = rd_cnt;
    push(8'h81); push(8'h55);
    rx_frame(8'h81, "t4", 13, gap);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("t4_stopped", bad, 0);
    chk("t4_rd_pulses", rd_cnt - base, 1);
    chk("t4_fifo_level", wr_ptr - rd_ptr, 1);
    chk("t4_count", count, 4'd5);

    // async reset in the fifth data bit of 0x55, then a fresh frame
    en = 1'b1; w = 0;
    while (tx !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t5_start_seen", (w < 50), 1'b1);
    repeat (21) @(negedge clk);
    chk("t5_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_async_rst", {tx, busy, count}, {1'b1, 1'b0, 4'd0});
    push(8'hC3);
    @(negedge clk);
    chk("t5_held_in_rst", {busy, rd_en, tx}, 3'b001);
    rst = 1'b0;
    rx_frame(8'hC3, "t5_fresh", -1, gap);
    chk("t5_fresh_latency", gap, 3);
    @(negedge clk);
    chk("t5_count", count, 4'd1);

    // 17 bytes through a 4-bit counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) push(8'(i * 7 + 1));
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(busy === 1'b0 && wr_ptr == rd_ptr) && w < 3000);
    chk("t6_drain_in_time", (w < 3000), 1'b1);
    chk("t6_count_wrap", count, 4'd1);
    chk("t6_all_popped", wr_ptr - rd_ptr, 0);

    // two stop bits: 44 clk from start bit to byte_done inclusive
    e2 = 1'b0; w = 0;
    while (rd_en2 !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    e2 = 1'b1;
    chk("t6b_rd_en_seen", (w < 20), 1'b1);
    w = 0;
    while (tx2 !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    len = 1;
    while (done2 !== 1'b1 && len < 100) begin
      @(negedge clk);
      len++;
    end
    chk("t6b_frame_len", len, 44);
    chk("t6b_tx_at_done", tx2, 1'b1);
    @(negedge clk);
    chk("t6b_idle", {busy2, count2}, {1'b0, 16'd1});

    chk("no_underflow_read", uf, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
